// File: rtl/frac_fir_mac_sched_if.sv
// -----------------------------------------------------------------------------
// frac_fir_mac_sched_if
//   Bundles the sample, result and coefficient-configuration handshakes of the
//   fractional-order FIR MAC sequencer.
//
//   Signals
//     in_valid / in_ready / in_data    : sample stream into the filter
//     out_valid / out_ready / out_data : filtered result stream
//     cfg_we / cfg_addr / cfg_data     : coefficient write request
//     cfg_ack                          : one-cycle pulse, write performed
//     busy                             : sequencer is not idle
//
//   Modports
//     slave  : the sequencer itself
//     master : the environment (source, sink and configuration agent)
// -----------------------------------------------------------------------------
interface frac_fir_mac_sched_if #(
  parameter int DW = 32,
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_ack;
  logic          busy;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ack, busy
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ack, busy
  );
endinterface

// File: rtl/frac_fir_mac_sched.sv
// -----------------------------------------------------------------------------
// frac_fir_mac_sched
//   Sequencer for a Gruenwald-Letnikov fractional-order FIR operator. A single
//   time-multiplexed DW x DW multiplier walks the ORDER taps of every accepted
//   sample; the module owns the sample delay line and a runtime-writable
//   coefficient bank. Samples and coefficients are signed fixed point with
//   FRAC fractional bits.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous, active-low reset
//     bus  : frac_fir_mac_sched_if.slave (sample in, result out, coefficient
//            write port, busy flag)
//
//   Build option
//     FRAC_FIR_SAT_EN : when defined, the result saturates to the DW-bit signed
//                       range instead of wrapping.
//
//   Timing: the product of tap i is registered, then added to the accumulator
//   on the following cycle, so MAC lasts ORDER+1 cycles and out_valid rises
//   after edge ORDER+1 counted from the accept edge.
// -----------------------------------------------------------------------------
module frac_fir_mac_sched #(
  parameter int ORDER = 3,
  parameter int DW    = 32,
  parameter int FRAC  = 24,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  frac_fir_mac_sched_if.slave  bus
);

  localparam int ACC_W = 48;
  localparam int PW    = 2 * DW;
  localparam int CW    = $clog2(ORDER + 1);
  localparam logic [CW-1:0] TAP_LAST = CW'(ORDER);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Reset values of the coefficient bank.
  function automatic logic [DW-1:0] coef_default(input int k);
    case (k)
      0:       return DW'(32'sd16777216);
      1:       return DW'(-32'sd11601444);
      2:       return DW'(-32'sd1078774);
      default: return '0;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    x_vec [ORDER];
  logic signed [DW-1:0]    c_vec [ORDER];
  logic [CW-1:0]           tap_q;
  logic [CW-1:0]           tap_sel;
  logic signed [DW-1:0]    x_sel, c_sel;
  logic signed [PW-1:0]    prod_full;
  logic signed [ACC_W-1:0] term_d, term_q;
  logic signed [ACC_W-1:0] acc_q, acc_sum;
  logic signed [DW-1:0]    final_val;
  logic signed [DW-1:0]    out_data_q;
  logic                    cfg_ack_q;
  logic                    accept;
  logic                    cfg_wr_en;

  assign accept = (state_q == IDLE) && bus.in_valid;

  // A pending sample wins over a coefficient write; the extra !cfg_ack_q term
  // stops a held cfg_we from writing twice while the ack is on the wire.
  assign cfg_wr_en = (state_q == IDLE) && !bus.in_valid && bus.cfg_we && !cfg_ack_q;

  // ---------------------------------------------------------------------------
  // Delay line and coefficient bank, one register pair per tap
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < ORDER; gi++) begin : g_tap
    localparam logic [DW-1:0] C_RST = coef_default(gi);
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] c_q;

    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst)        x_q <= '0;
        else if (accept) x_q <= bus.in_data;
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (!rst)        x_q <= '0;
        else if (accept) x_q <= x_vec[gi-1];
      end
    end

    // Out-of-range addresses simply match no tap; the ack still pulses.
    always_ff @(posedge clk) begin
      if (!rst)                                          c_q <= C_RST;
      else if (cfg_wr_en && (bus.cfg_addr == AW'(gi)))   c_q <= bus.cfg_data;
    end

    assign x_vec[gi] = x_q;
    assign c_vec[gi] = c_q;
  end

  // ---------------------------------------------------------------------------
  // Shared multiplier and accumulator
  // ---------------------------------------------------------------------------
  // During the final MAC cycle (tap_q == ORDER) no product is needed; park the
  // select on tap 0 so the index never leaves the array.
  assign tap_sel = (tap_q == TAP_LAST) ? '0 : tap_q;
  assign x_sel   = x_vec[tap_sel];
  assign c_sel   = c_vec[tap_sel];

  assign prod_full = {{DW{x_sel[DW-1]}}, x_sel} * {{DW{c_sel[DW-1]}}, c_sel};
  // Arithmetic shift floors toward minus infinity.
  assign term_d    = ACC_W'(prod_full >>> FRAC);
  assign acc_sum   = acc_q + term_q;

`ifdef FRAC_FIR_SAT_EN
  // In range when every bit above the DW-bit sign bit copies the MSB.
  always_comb begin
    if (acc_sum[ACC_W-1:DW-1] == {(ACC_W-DW+1){acc_sum[ACC_W-1]}}) begin
      final_val = DW'(acc_sum);
    end else if (acc_sum[ACC_W-1]) begin
      final_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      final_val = {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign final_val = DW'(acc_sum);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = MAC;
      end
      MAC: begin
        if (tap_q == TAP_LAST) state_d = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      tap_q      <= '0;
      term_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      cfg_ack_q  <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_wr_en;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            tap_q <= '0;
            acc_q <= '0;
          end
        end
        MAC: begin
          if (tap_q != TAP_LAST) term_q <= term_d;
          // term_q is stale on the first MAC cycle, so skip that add.
          if (tap_q != '0)       acc_q  <= acc_sum;
          if (tap_q == TAP_LAST) out_data_q <= final_val;
          tap_q <= tap_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.cfg_ack  = cfg_ack_q;

endmodule

// File: tb/tb_frac_fir_mac_sched.sv
// -----------------------------------------------------------------------------
// tb_frac_fir_mac_sched
//   Directed bench for frac_fir_mac_sched. Expected results are pushed to a
//   queue when a sample is offered and popped when the result handshake
//   completes. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_frac_fir_mac_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frac_fir_mac_sched_if #(.DW(32), .AW(2)) bus_if ();

  frac_fir_mac_sched #(
    .ORDER (3),
    .DW    (32),
    .FRAC  (24),
    .AW    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

`ifdef FRAC_FIR_SAT_EN
  localparam logic [31:0] OVF_POS = 32'h7FFFFFFF;
  localparam logic [31:0] OVF_NEG = 32'h80000000;
`else
  localparam logic [31:0] OVF_POS = 32'hFFFFFF00;
  localparam logic [31:0] OVF_NEG = 32'h00000080;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  longint      m_x [3];
  longint      m_c [3];

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] b32(input logic v);
    return {31'b0, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  // Reference filter: 64-bit exact products, floor shift, then wrap or clamp.
  function automatic void model_reset();
    for (int k = 0; k < 3; k++) m_x[k] = 0;
    m_c[0] = 16777216;
    m_c[1] = -11601444;
    m_c[2] = -1078774;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] s);
    longint acc;
    for (int k = 2; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = longint'($signed(s));
    acc = 0;
    for (int k = 0; k < 3; k++) acc += (m_x[k] * m_c[k]) >>> 24;
`ifdef FRAC_FIR_SAT_EN
    if (acc > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (acc < -64'sd2147483648) return 32'h80000000;
`endif
    return 32'(acc);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] e);
    check("in_ready_before_send", b32(bus_if.in_ready), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    exp_q.push_back(e);
    tick();
    bus_if.in_valid = 1'b0;
    $display("sample 0x%08h accepted, expect 0x%08h", d, e);
  endtask

  task automatic collect(input bit chk_lat);
    int          n;
    logic [31:0] e;
    n = 0;
    bus_if.out_ready = 1'b1;
    while (!bus_if.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_seen", b32(bus_if.out_valid), 32'd1);
    if (chk_lat) check("latency", 32'(n), 32'd4);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check("out_data", bus_if.out_data, e);
    $display("result 0x%08h after %0d cycles, expect 0x%08h", bus_if.out_data, n, e);
    tick();
    check("idle_after_out", b32(bus_if.in_ready), 32'd1);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = a;
    bus_if.cfg_data = d;
    do begin
      tick();
      n++;
    end while (!bus_if.cfg_ack && n < 10);
    check("cfg_ack_latency", 32'(n), 32'd1);
    bus_if.cfg_we = 1'b0;
    if (a < 2'd3) m_c[a] = longint'($signed(d));
    tick();
    check("cfg_ack_pulse", b32(bus_if.cfg_ack), 32'd0);
    $display("cfg write addr %0d data 0x%08h ack after %0d cycles", a, d, n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic impulse_run();
    void'(model_step(32'h01000000)); send(32'h01000000, 32'h01000000); collect(1'b1);
    void'(model_step(32'h00000000)); send(32'h00000000, 32'hFF4EF9DC); collect(1'b1);
    void'(model_step(32'h00000000)); send(32'h00000000, 32'hFFEF8A0A); collect(1'b1);
    void'(model_step(32'h00000000)); send(32'h00000000, 32'h00000000); collect(1'b1);
  endtask

  initial begin
    int w;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;
    bus_if.cfg_we    = 1'b0;
    bus_if.cfg_addr  = '0;
    bus_if.cfg_data  = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    rst = 1'b1;
    check("rst_in_ready",  b32(bus_if.in_ready),  32'd1);
    check("rst_out_valid", b32(bus_if.out_valid), 32'd0);
    check("rst_out_data",  bus_if.out_data,       32'd0);
    check("rst_cfg_ack",   b32(bus_if.cfg_ack),   32'd0);
    check("rst_busy",      b32(bus_if.busy),      32'd0);

    // Impulse response with default coefficients
    impulse_run();

    // Backpressure; an in_valid offered during OUT must be ignored
    bus_if.out_ready = 1'b0;
    send(32'h01000000, model_step(32'h01000000));
    w = 0;
    while (!bus_if.out_valid && w < 20) begin
      tick();
      w++;
    end
    check("bp_out_valid_rise", b32(bus_if.out_valid), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h7FFFFFFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold_valid",    b32(bus_if.out_valid), 32'd1);
      check("bp_hold_data",     bus_if.out_data,       32'h01000000);
      check("bp_hold_in_ready", b32(bus_if.in_ready),  32'd0);
      check("bp_hold_busy",     b32(bus_if.busy),      32'd1);
    end
    bus_if.in_valid = 1'b0;
    collect(1'b0);
    check("bp_release_valid", b32(bus_if.out_valid), 32'd0);
    check("bp_release_busy",  b32(bus_if.busy),      32'd0);
    send(32'h00000000, model_step(32'h00000000));
    collect(1'b1);

    // Coefficient write in IDLE
    do_reset();
    cfg_write(2'd0, 32'h02000000);
    send(32'h01000000, model_step(32'h01000000));
    collect(1'b1);

    // Write requested during MAC is deferred until IDLE
    send(32'h00000000, model_step(32'h00000000));
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = 2'd1;
    bus_if.cfg_data = 32'h00000000;
    check("defer_no_ack_mac", b32(bus_if.cfg_ack), 32'd0);
    collect(1'b1);
    check("defer_no_ack_idle", b32(bus_if.cfg_ack), 32'd0);
    tick();
    check("defer_ack", b32(bus_if.cfg_ack), 32'd1);
    bus_if.cfg_we = 1'b0;
    m_c[1] = 0;
    tick();
    check("defer_ack_pulse", b32(bus_if.cfg_ack), 32'd0);
    send(32'h00000000, model_step(32'h00000000)); collect(1'b1);
    send(32'h01000000, model_step(32'h01000000)); collect(1'b1);
    send(32'h00000000, model_step(32'h00000000)); collect(1'b1);

    // Out-of-range address: ack but no coefficient change
    cfg_write(2'd3, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      send(32'h01000000, model_step(32'h01000000));
      collect(1'b1);
    end

    // Overflow
    do_reset();
    cfg_write(2'd0, 32'h7FFFFFFF);
    cfg_write(2'd1, 32'h00000000);
    cfg_write(2'd2, 32'h00000000);
    void'(model_step(32'h7FFFFFFF)); send(32'h7FFFFFFF, OVF_POS); collect(1'b1);
    void'(model_step(32'h80000000)); send(32'h80000000, OVF_NEG); collect(1'b1);

    // Reset during MAC tap 1
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h01000000;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    do_reset();
    check("midrst_in_ready",  b32(bus_if.in_ready),  32'd1);
    check("midrst_busy",      b32(bus_if.busy),      32'd0);
    check("midrst_out_valid", b32(bus_if.out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midrst_no_valid", b32(bus_if.out_valid), 32'd0);
    end
    impulse_run();

    // Sample and write offered together: sample first, write after the result
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 32'h01000000;
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = 2'd0;
    bus_if.cfg_data = 32'h00800000;
    exp_q.push_back(model_step(32'h01000000));
    tick();
    bus_if.in_valid = 1'b0;
    check("simul_no_ack", b32(bus_if.cfg_ack), 32'd0);
    check("simul_busy",   b32(bus_if.busy),    32'd1);
    collect(1'b1);
    check("simul_no_ack_idle", b32(bus_if.cfg_ack), 32'd0);
    tick();
    check("simul_ack", b32(bus_if.cfg_ack), 32'd1);
    bus_if.cfg_we = 1'b0;
    m_c[0] = 32'sh00800000;
    tick();
    check("simul_ack_pulse", b32(bus_if.cfg_ack), 32'd0);
    send(32'h01000000, model_step(32'h01000000));
    collect(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
